// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Debug/trace master that walks every register of the register file through
//   one asynchronous read port and streams each (address, data) pair out on a
//   valid/ready interface. It never writes the register file.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      begin a dump (only looked at while idle)
//   abort      cancel an active dump (ignored while idle)
//   ra         read address to the register-file read port (idx, 0 when idle)
//   rd         combinational read data for ra
//   busy       high while a dump is in progress (FETCH, SEND, DONE)
//   out_valid  out_addr/out_data hold a beat
//   out_ready  consumer accepts the beat
//   out_addr   register index of the current beat
//   out_data   register contents of the current beat
//   done       one-cycle pulse after the last beat is accepted
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  if ((1 << ADDR_W) < NUM_REGS) begin : g_bad_addr_w
    $error("ADDR_W too narrow for NUM_REGS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  // Index of the last register; idx stops here, so it never wraps.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;

  // idx is held at 0 whenever idle, so the read port sees 0 outside a dump.
  assign ra   = idx;
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort wins over out_ready: a beat on the bus this cycle is dropped.
      state     <= S_IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // rd has had a full cycle to settle for ra == idx; capture it.
          out_data  <= rd;
          out_addr  <= idx;
          out_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          idx   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Testbench for regfile_dump_reader: a per-cycle vector table for reset,
// start and handshake timing, then directed multi-cycle sequences for full
// dumps, backpressure, start-while-busy, abort, reset mid-dump and
// back-to-back dumps. The register file is a small array model in the bench.
module tb_regfile_dump_reader;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              done;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              corrupt;

  // Register-file read port; corrupt flips the data to prove the captured
  // beat is held and not passed through from rd.
  assign rd = corrupt ? ~rf[ra] : rf[ra];

  regfile_dump_reader #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ra       (ra),
    .rd       (rd),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  // Beats accepted and done pulses, sampled mid-cycle: inputs only change
  // just after a rising edge, so these are the values the next edge sees.
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_data [$];
  int                done_cnt;

  always @(negedge clk) begin
    if (!rst && !abort && out_valid && out_ready) begin
      log_addr.push_back(out_addr);
      log_data.push_back(out_data);
    end
    if (!rst && done) done_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one dump from idle. bp_addr/bp_len: hold out_ready low for bp_len
  // edges on that beat. start_at: pulse start while that beat is on the bus.
  task automatic run_dump(input string tag, input int bp_addr, input int bp_len,
                          input int start_at, input bit post_idle, input bit lit_chk);
    int c;
    int hold;
    int done_c;
    int idle_c;
    bit sp;
    logic [DATA_W-1:0] saved;
    clear_log();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start  = 1'b0;
    c      = 0;
    hold   = 0;
    done_c = -1;
    idle_c = -1;
    sp     = 1'b0;
    saved  = '0;
    while (c < 400) begin
      step();
      c++;
      start = 1'b0;
      if (done && done_c < 0) done_c = c;
      if (!busy) begin
        idle_c = c;
        break;
      end
      if (hold > 0 && hold <= bp_len) begin
        chk($sformatf("%s_hold%0d_valid", tag, hold), 32'(out_valid), 32'd1);
        chk($sformatf("%s_hold%0d_addr", tag, hold), 32'(out_addr), 32'(bp_addr));
        chk($sformatf("%s_hold%0d_data", tag, hold), out_data, saved);
      end
      if (hold == 0 && bp_len > 0 && out_valid && int'(out_addr) == bp_addr) begin
        saved     = out_data;
        corrupt   = 1'b1;
        out_ready = 1'b0;
        hold      = 1;
      end else if (hold >= 1 && hold < bp_len) begin
        out_ready = 1'b0;
        hold++;
      end else if (hold == bp_len && hold > 0) begin
        corrupt   = 1'b0;
        out_ready = 1'b1;
        hold++;
      end
      if (!sp && start_at >= 0 && out_valid && int'(out_addr) == start_at) begin
        start = 1'b1;
        sp    = 1'b1;
      end
    end
    corrupt = 1'b0;
    start   = 1'b0;
    if (idle_c < 0) timeout({tag, "_busy_fall"});
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(2 * NUM_REGS + bp_len));
    chk({tag, "_idle_cycle"}, 32'(idle_c), 32'(2 * NUM_REGS + 1 + bp_len));
    chk({tag, "_beat_count"}, 32'(log_addr.size()), 32'(NUM_REGS));
    for (int i = 0; i < log_addr.size() && i < NUM_REGS; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[i]), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), log_data[i], rf[i]);
    end
    if (lit_chk && log_data.size() >= NUM_REGS) begin
      chk({tag, "_lit_beat0"}, log_data[0], 32'h0000_0000);
      chk({tag, "_lit_beat1"}, log_data[1], 32'h1111_1111);
      chk({tag, "_lit_beat2"}, log_data[2], 32'h0000_0002);
      chk({tag, "_lit_beat31"}, log_data[31], 32'hDEAD_BEEF);
    end
    if (post_idle) begin
      repeat (6) step();
      chk({tag, "_post_busy"}, 32'(busy), 32'd0);
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_beats"}, 32'(log_addr.size()), 32'(NUM_REGS));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    end
  endtask

  typedef struct {
    logic              rst;
    logic              start;
    logic              abort;
    logic              rdy;
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ra;
    logic              cd;   // compare out_addr/out_data in this row
  } vec_t;

  vec_t tv [12];

  initial begin
    bit found;
    n_cmp     = 0;
    n_fail    = 0;
    done_cnt  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    corrupt   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = '0;
    rf[1]  = 32'h1111_1111;
    rf[2]  = 32'h0000_0002;
    rf[31] = 32'hDEAD_BEEF;

    //          rst start abort rdy  vld addr data           busy done ra cd
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 1'b1};
    tv[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 1'b1};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 5'd0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0,          1'b1, 1'b0, 5'd0, 1'b1};
    tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,          1'b1, 1'b0, 5'd1, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1111_1111,  1'b1, 1'b0, 5'd1, 1'b1};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1111_1111,  1'b1, 1'b0, 5'd1, 1'b1};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1111_1111,  1'b1, 1'b0, 5'd1, 1'b1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 32'h1111_1111,  1'b1, 1'b0, 5'd2, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_0002,  1'b1, 1'b0, 5'd2, 1'b1};
    tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h0000_0002,  1'b0, 1'b0, 5'd0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,          1'b0, 1'b0, 5'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      rst       = tv[i].rst;
      start     = tv[i].start;
      abort     = tv[i].abort;
      out_ready = tv[i].rdy;
      step();
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tv[i].vld));
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("tv%0d_done", i), 32'(done), 32'(tv[i].done));
      chk($sformatf("tv%0d_ra", i), 32'(ra), 32'(tv[i].ra));
      if (tv[i].cd) begin
        chk($sformatf("tv%0d_addr", i), 32'(out_addr), 32'(tv[i].addr));
        chk($sformatf("tv%0d_data", i), out_data, tv[i].data);
      end
    end
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    step();

    // Full dump with ready high, then a second dump started the cycle after done.
    run_dump("full", -1, 0, -1, 1'b0, 1'b1);
    run_dump("b2b", -1, 0, -1, 1'b1, 1'b1);

    // Non-zero pattern everywhere except x0 for the remaining sequences.
    for (int i = 1; i < NUM_REGS; i++) rf[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;

    run_dump("bp", 3, 5, -1, 1'b1, 1'b0);
    run_dump("startbusy", -1, 0, 10, 1'b1, 1'b0);

    // Abort while beat 7 is on the bus with ready high.
    clear_log();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (out_valid && out_addr == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) timeout("abort_reach_beat7");
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ra", 32'(ra), 32'd0);
    repeat (5) step();
    chk("abort_beats", 32'(log_addr.size()), 32'd7);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_dump("after_abort", -1, 0, -1, 1'b1, 1'b0);

    // Reset during the FETCH of idx 20.
    clear_log();
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (busy && !out_valid && ra == 5'd20) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) timeout("rst_reach_fetch20");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ra", 32'(ra), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    repeat (8) step();
    chk("rst_beats", 32'(log_addr.size()), 32'd20);
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    chk("rst_idle_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace master that walks the 32-entry register file through one of its asynchronous read ports.
- Streams each (address, data) pair out on a valid/ready interface to the debug/trace path.
- Sits beside the datapath and owns the read-address mux input while busy; never writes the register file.

Parameters:
- NUM_REGS, 32, number of registers read per dump; indices 0..NUM_REGS-1.
- ADDR_W, 5, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a dump; sampled only in IDLE.
- abort  input  1  cancel an active dump; sampled in any state except IDLE.
- ra  output  ADDR_W  read address to the register-file read port.
- rd  input  DATA_W  combinational read data returned for ra.
- busy  output  1  high in FETCH, SEND and DONE.
- out_valid  output  1  out_addr/out_data hold a valid beat.
- out_ready  input  1  consumer accepts the beat.
- out_addr  output  ADDR_W  register index of the current beat.
- out_data  output  DATA_W  register contents of the current beat.
- done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (rst=1 at an edge), from any state: state<=IDLE, idx<=0, out_valid<=0, out_addr<=0, out_data<=0, done<=0.
  - ra=0 and busy=0 during and after reset.
  - Reset mid-dump discards the dump: no done pulse, no further beats.
- ra is driven from idx in every state (0 in IDLE). out_* and done are registered outputs.
- FSM states: IDLE, FETCH, SEND, DONE.
  - IDLE: start=1 → idx<=0, go to FETCH. start=0 → stay in IDLE.
  - FETCH (exactly one cycle): ra=idx, rd is settled.
    - At the edge: out_data<=rd, out_addr<=idx, out_valid<=1, go to SEND.
  - SEND: out_valid=1. out_addr and out_data are held stable until accepted.
    - out_ready=1 at the edge: the beat is accepted, out_valid<=0.
    - If idx==NUM_REGS-1 → go to DONE. Otherwise idx<=idx+1 → go to FETCH.
    - out_ready=0: stay in SEND, all outputs unchanged. The wait is unbounded.
  - DONE (one cycle): done=1 → go to IDLE, idx<=0.
- abort=1 at an edge in FETCH/SEND/DONE: go to IDLE, out_valid<=0, done<=0, idx<=0.
  - abort has priority over out_ready. A beat presented in that cycle counts as not accepted.
- start while not IDLE is ignored; it is neither queued nor a restart.
- Timing, with start sampled at edge E:
  - out_valid rises after edge E+1.
  - With out_ready tied high, beat k is accepted at edge E+2+2k.
  - done is high in the cycle following edge E+2*NUM_REGS.
  - busy falls after edge E+2*NUM_REGS+1.
  - Peak throughput is one beat per 2 cycles.
- Register x0 reads 0 through the register file; the block does not special-case it.
- idx never wraps. The final comparison is against NUM_REGS-1, so no index beyond it is ever presented on ra.

Test Plan:
- Full dump, ready high: preload x1=0x11111111, x2=0x00000002, x31=0xDEADBEEF, others 0; pulse start at edge E.
  - Expect exactly 32 beats with out_addr 0..31 in order.
  - Data: beat0=0x00000000, beat1=0x11111111, beat2=0x00000002, beat31=0xDEADBEEF.
  - done pulses once in the cycle after E+64; busy low after E+65.
- Backpressure: out_ready low for 5 cycles on beat 3, then high.
  - out_valid stays 1 with out_addr=3 and out_data unchanged for all 5 cycles.
  - Beat 3 is accepted exactly once; beat 4 follows normally.
- Start while busy: pulse start at beat 10.
  - Sequence is unaffected; done pulses once; no second dump begins.
- Abort: assert abort while in SEND with out_addr=7 and out_ready=1.
  - Next cycle: IDLE, out_valid=0, no done, and beat 7 is not counted.
  - A new start then dumps from address 0.
- Reset mid-dump: assert rst during FETCH of idx=20.
  - After that edge: out_valid=0, done=0, busy=0, ra=0.
  - No beats or done pulse follow until the next start.
- Back-to-back dumps: assert start in the cycle right after done.
  - A second full 32-beat dump completes with addresses 0..31 and the same data.
